// File: rtl/m1_pkg.sv
// Shared types and helpers for the m1 result checker.
// Frame beat states, beat indices and the byte-swap used on hash words.
package m1_pkg;

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2,
        WAIT3 = 2'd3
    } frame_st_t;

    localparam logic [1:0] BEAT_H0 = 2'd0;
    localparam logic [1:0] BEAT_H6 = 2'd2;
    localparam logic [1:0] BEAT_H7 = 2'd3;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/m1_res_fifo.sv
// Synchronous result FIFO with count and overflow strobe.
// Full push+pop performs both; a pop on empty is ignored.
module m1_res_fifo
    import m1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count,
    output logic          o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hold;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp   <= r_rp + 1'b1;
                r_hold <= r_mem[r_rp];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Once drained, keep showing the entry that was popped last.
    assign o_data  = w_empty ? r_hold : r_mem[r_rp];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_cnt;
    assign o_ovf   = i_push && w_full && !w_pop;

endmodule

// File: rtl/m1_result_chk.sv
// Collects SHA-256 final-hash beats, tests H7:H6 against a target, queues hits.
// Optional M1_RESULT_FULL_HASH_EN keeps all eight words of the last frame.
module m1_result_chk
    import m1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                        clk_h,
    input  logic                        rst_n,
    input  logic [31:0]                 m1_h_0_3,
    input  logic [31:0]                 m1_h_4_7,
    input  logic                        m1_hash_valid,
    input  logic [1:0]                  m1_hash_beat,
    input  logic [31:0]                 m1_hash_nonce,
    input  logic [31:0]                 data_from_host,
    input  logic                        tgt_wr,
    input  logic                        tgt_sel,
    input  logic                        res_rd,
    input  logic                        err_clr,
    output logic [31:0]                 res_nonce,
    output logic                        res_empty,
    output logic                        res_full,
    output logic [$clog2(FIFO_DEPTH):0] res_count,
    output logic                        res_ovf,
    output logic                        seq_err,
    output logic                        hit_pulse,
    output logic [CNT_W-1:0]            hash_cnt
`ifdef M1_RESULT_FULL_HASH_EN
    ,
    input  logic [2:0]                  hash_rd_sel,
    output logic [31:0]                 hash_rd_data
`endif
);

    frame_st_t        r_state;
    frame_st_t        w_state_nx;
    logic [1:0]       w_exp;
    logic             w_beat_ok;
    logic             w_beat_bad;
    logic             w_beat0;
    logic             w_last;
    logic [31:0]      r_nonce;
    logic [31:0]      r_w6;
    logic [31:0]      w_w7;
    logic [31:0]      r_tgt_hi;
    logic [31:0]      r_tgt_lo;
    logic             w_hit;
    logic             r_done;
    logic             r_hit;
    logic             r_seq_err;
    logic             r_ovf;
    logic             w_ovf_evt;
    logic [CNT_W-1:0] r_hash_cnt;

    assign w_exp = r_state;

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT0;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_beat_ok  = 1'b0;
        w_beat_bad = 1'b0;
        if (m1_hash_valid) begin
            if (m1_hash_beat == w_exp) begin
                w_beat_ok = 1'b1;
                unique case (r_state)
                    WAIT0: w_state_nx = WAIT1;
                    WAIT1: w_state_nx = WAIT2;
                    WAIT2: w_state_nx = WAIT3;
                    WAIT3: w_state_nx = WAIT0;
                    default: w_state_nx = WAIT0;
                endcase
            end else begin
                // An out-of-order beat 0 restarts the frame instead of losing it.
                w_beat_bad = 1'b1;
                w_state_nx = (m1_hash_beat == BEAT_H0) ? WAIT1 : WAIT0;
            end
        end
    end

    assign w_beat0 = m1_hash_valid && (m1_hash_beat == BEAT_H0);
    assign w_last  = w_beat_ok && (m1_hash_beat == BEAT_H7);
    assign w_w7    = bswap32(m1_h_4_7);
    assign w_hit   = (w_w7 < r_tgt_hi) ||
                     ((w_w7 == r_tgt_hi) && (r_w6 <= r_tgt_lo));

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_nonce    <= '0;
            r_w6       <= '0;
            r_tgt_hi   <= '0;
            r_tgt_lo   <= '0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_seq_err  <= 1'b0;
            r_ovf      <= 1'b0;
            r_hash_cnt <= '0;
        end else begin
            if (w_beat0) begin
                r_nonce <= m1_hash_nonce;
            end
            if (w_beat_ok && (m1_hash_beat == BEAT_H6)) begin
                r_w6 <= bswap32(m1_h_4_7);
            end
            // Frame compare sees the pre-write target on a same-cycle write.
            if (tgt_wr) begin
                if (tgt_sel) begin
                    r_tgt_lo <= data_from_host;
                end else begin
                    r_tgt_hi <= data_from_host;
                end
            end
            r_done <= w_last;
            r_hit  <= w_last && w_hit;
            if (r_done) begin
                r_hash_cnt <= r_hash_cnt + 1'b1;
            end
            if (w_beat_bad) begin
                r_seq_err <= 1'b1;
            end else if (err_clr) begin
                r_seq_err <= 1'b0;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    m1_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk_h),
        .rst_n   (rst_n),
        .i_push  (r_hit),
        .i_data  (r_nonce),
        .i_pop   (res_rd),
        .o_data  (res_nonce),
        .o_empty (res_empty),
        .o_full  (res_full),
        .o_count (res_count),
        .o_ovf   (w_ovf_evt)
    );

    assign res_ovf   = r_ovf;
    assign seq_err   = r_seq_err;
    assign hit_pulse = r_hit;
    assign hash_cnt  = r_hash_cnt;

`ifdef M1_RESULT_FULL_HASH_EN
    logic [31:0] r_pend [8];
    logic [31:0] r_hash [8];

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_pend[i] <= '0;
                r_hash[i] <= '0;
            end
        end else begin
            if (m1_hash_valid) begin
                r_pend[{1'b0, m1_hash_beat}] <= m1_h_0_3;
                r_pend[{1'b1, m1_hash_beat}] <= m1_h_4_7;
            end
            if (r_done) begin
                for (int i = 0; i < 8; i++) begin
                    r_hash[i] <= r_pend[i];
                end
            end
        end
    end

    assign hash_rd_data = r_hash[hash_rd_sel];
`else
    logic w_unused_h03;
    assign w_unused_h03 = ^m1_h_0_3;
`endif

endmodule
